fifo_rd_stream: RTL and testbench

- Read-side controller for the async FIFO.
- Owns the read binary/Gray pointers and the empty flag, and drives the memory read port (rclken, raddr, rempty).
- Absorbs the memory's one-cycle registered read latency and presents the popped words as a valid/ready stream with a 2-entry output buffer, sustaining one word per cycle.
- Sits in the rclk domain, between the write-pointer synchronizer output (rq2_wptr) and the downstream consumer.

---
 rtl/fifo_pkg.sv | 17 +
 rtl/fifo_rd_stream_if.sv | 16 +
 rtl/fifo_skid2.sv | 63 ++++++
 rtl/fifo_rd_stream.sv | 84 ++++++++
 tb/tb_fifo_rd_stream.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO read and write sides.
// Contents:
//   PKG_DATA_WIDTH / PKG_ADDR_WIDTH - default word width and memory address width
//   FIFO_DEPTH                      - number of memory entries (1 << PKG_ADDR_WIDTH)
//   ptr_t                           - binary/Gray pointer type, one bit wider than the address
//   bin2gray                        - binary to reflected Gray conversion
package fifo_pkg;
  localparam int unsigned PKG_DATA_WIDTH = 8;
  localparam int unsigned PKG_ADDR_WIDTH = 4;
  localparam int unsigned FIFO_DEPTH     = 1 << PKG_ADDR_WIDTH;

  typedef logic [PKG_ADDR_WIDTH:0] ptr_t;

  function automatic ptr_t bin2gray(input ptr_t b);
    return (b >> 1) ^ b;
  endfunction
endpackage

// File: rtl/fifo_rd_stream_if.sv
// Valid/ready output stream of the FIFO read side.
// Signals:
//   m_valid - word available (producer -> consumer)
//   m_data  - word, stable while m_valid && !m_ready
//   m_ready - consumer accepts m_data this cycle
// Modports: master (producer side), slave (consumer side).
interface fifo_rd_stream_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  m_valid;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_ready;

  modport master (output m_valid, output m_data, input  m_ready);
  modport slave  (input  m_valid, input  m_data, output m_ready);
endinterface

// File: rtl/fifo_skid2.sv
// Two-entry output buffer that turns memory read returns into a valid/ready stream.
// Ports:
//   rclk, rrst - clock and asynchronous active-high reset
//   in_valid   - a memory read word arrives this cycle (never refused)
//   in_data    - the arriving word
//   m          - output stream (master modport); head entry drives m_data
//   cnt        - number of buffered words (0..2), used by the issue rule upstream
module fifo_skid2
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = PKG_DATA_WIDTH
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  fifo_rd_stream_if.master      m,
  output logic [1:0]            cnt
);

  logic [1:0]            r_cnt;
  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_tail;
  logic                  w_pop;

  assign w_pop = m.m_valid && m.m_ready;

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      r_cnt  <= '0;
      r_head <= '0;
      r_tail <= '0;
    end else begin
      unique case ({in_valid, w_pop})
        2'b10: begin
          if (r_cnt == 2'd0) r_head <= in_data;
          else               r_tail <= in_data;
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          r_head <= r_tail;
          r_cnt  <= r_cnt - 2'd1;
        end
        2'b11: begin
          // Push and pop together: count holds, the arriving word goes behind
          // whatever remains after the head leaves.
          if (r_cnt == 2'd2) begin
            r_head <= r_tail;
            r_tail <= in_data;
          end else begin
            r_head <= in_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign m.m_valid = (r_cnt != 2'd0);
  assign m.m_data  = r_head;
  assign cnt       = r_cnt;

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side controller of the async FIFO (rclk domain).
// Owns the read binary/Gray pointers and the registered empty flag, drives the
// memory read port and hides the memory's one-cycle read latency behind a
// two-entry output buffer, sustaining one word per cycle.
// Ports:
//   rclk, rrst - read clock and asynchronous active-high reset
//   rq2_wptr   - write Gray pointer, already synchronized into rclk
//   mem_rdata  - registered memory read data, valid the cycle after a read issue
//   rclken     - memory read enable (read issued this cycle)
//   raddr      - memory read address
//   rempty     - registered empty flag
//   rptr       - read Gray pointer for the write-domain synchronizer
//   m          - output valid/ready stream (master modport)
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = PKG_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = PKG_ADDR_WIDTH
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic [ADDR_WIDTH:0]   rq2_wptr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  rclken,
  output logic [ADDR_WIDTH-1:0] raddr,
  output logic                  rempty,
  output logic [ADDR_WIDTH:0]   rptr,
  fifo_rd_stream_if.master      m
);

  logic [ADDR_WIDTH:0] r_rbin;
  logic [ADDR_WIDTH:0] r_rptr;
  logic                r_rempty;
  logic                r_inflight;

  logic [1:0]          w_cnt;
  logic                w_pop;
  logic [2:0]          w_occ;
  logic                w_issue;
  logic [ADDR_WIDTH:0] w_rbin_next;
  logic [ADDR_WIDTH:0] w_rgray_next;

  assign w_pop = m.m_valid && m.m_ready;

  // Occupancy after this cycle's pop, counting the word still in the memory
  // pipeline; keeping it below 2 guarantees every returning word has a slot.
  always_comb begin
    w_occ        = {1'b0, w_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
    w_issue      = !r_rempty && (w_occ < 3'd2);
    w_rbin_next  = r_rbin + {{ADDR_WIDTH{1'b0}}, w_issue};
    w_rgray_next = bin2gray(w_rbin_next);
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      r_rbin     <= '0;
      r_rptr     <= '0;
      r_rempty   <= 1'b1;
      r_inflight <= 1'b0;
    end else begin
      r_rbin     <= w_rbin_next;
      r_rptr     <= w_rgray_next;
      r_rempty   <= (w_rgray_next == rq2_wptr);
      r_inflight <= w_issue;
    end
  end

  assign rclken = w_issue;
  assign raddr  = r_rbin[ADDR_WIDTH-1:0];
  assign rempty = r_rempty;
  assign rptr   = r_rptr;

  fifo_skid2 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .rclk     (rclk),
    .rrst     (rrst),
    .in_valid (r_inflight),
    .in_data  (mem_rdata),
    .m        (m),
    .cnt      (w_cnt)
  );

endmodule

// File: tb/tb_fifo_rd_stream.sv
module tb_fifo_rd_stream;
  logic       rclk = 1'b0;
  logic       rrst;
  logic [4:0] rq2_wptr;
  logic [7:0] mem_rdata;
  logic       rclken;
  logic [3:0] raddr;
  logic       rempty;
  logic [4:0] rptr;

  logic       ready_dir;
  logic       rnd;
  logic       r_rand;
  logic [4:0] wbin;
  logic [7:0] mem [16];

  logic [7:0] exp_d [$];
  logic [3:0] exp_a [$];

  int         n_cmp = 0;
  int         n_fail = 0;
  logic       track_msb;
  logic       prev_msb;
  int         msb_toggles;
  logic       saw_wrap;
  logic [3:0] last_addr;

  always #5 rclk = ~rclk;

  fifo_rd_stream_if #(.DATA_WIDTH(8)) s ();
  assign s.m_ready = rnd ? r_rand : ready_dir;

  fifo_rd_stream #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (4)
  ) dut (
    .rclk      (rclk),
    .rrst      (rrst),
    .rq2_wptr  (rq2_wptr),
    .mem_rdata (mem_rdata),
    .rclken    (rclken),
    .raddr     (raddr),
    .rempty    (rempty),
    .rptr      (rptr),
    .m         (s.master)
  );

  // Memory with one-cycle registered read, drives 0 when not read.
  always @(posedge rclk or posedge rrst) begin
    if (rrst) mem_rdata <= 8'h00;
    else      mem_rdata <= (rclken && !rempty) ? mem[raddr] : 8'h00;
  end

  function automatic logic [4:0] gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_word(input logic [7:0] d);
    mem[wbin[3:0]] = d;
    exp_d.push_back(d);
    exp_a.push_back(wbin[3:0]);
    wbin = wbin + 5'd1;
  endtask

  task automatic publish();
    rq2_wptr = gray(wbin);
  endtask

  task automatic drain(input int unsigned budget, input string name);
    logic done;
    done = 1'b0;
    for (int unsigned i = 0; i < budget && !done; i++) begin
      @(negedge rclk);
      if (exp_d.size() == 0 && !s.m_valid && rempty && !rclken) done = 1'b1;
    end
    check(name, done, 1'b1);
    check({name, "_addrq"}, exp_a.size(), 0);
  endtask

  // Random ready source
  initial begin
    r_rand = 1'b0;
    forever begin
      @(posedge rclk);
      #1 r_rand = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: output words, read addresses, pointer MSB toggles
  initial begin
    forever begin
      @(negedge rclk);
      if (s.m_valid && s.m_ready) begin
        if (exp_d.size() == 0) check("data_unexpected", {24'd0, s.m_data}, 32'hFFFF_FFFF);
        else                   check("data", s.m_data, exp_d.pop_front());
      end
      if (rclken) begin
        if (exp_a.size() == 0) check("raddr_unexpected", {28'd0, raddr}, 32'hFFFF_FFFF);
        else                   check("raddr", raddr, exp_a.pop_front());
        if (last_addr == 4'd15 && raddr == 4'd0) saw_wrap = 1'b1;
        last_addr = raddr;
      end
      if (track_msb) begin
        if (rptr[4] != prev_msb) msb_toggles++;
        prev_msb = rptr[4];
      end
    end
  end

  initial begin
    int unsigned n;
    logic        ok;
    rrst = 1'b1; rq2_wptr = '0; ready_dir = 1'b0; rnd = 1'b0; wbin = '0;
    track_msb = 1'b0; prev_msb = 1'b0; msb_toggles = 0; saw_wrap = 1'b0; last_addr = 4'd0;
    repeat (3) @(posedge rclk);
    #1 rrst = 1'b0;

    // Idle after reset
    for (int i = 0; i < 20; i++) begin
      @(negedge rclk);
      check("idle", {rempty, rclken, s.m_valid, rptr}, {1'b1, 1'b0, 1'b0, 5'b00000});
    end

    // Three words, consumer always ready
    @(posedge rclk); #1;
    ready_dir = 1'b1;
    push_word(8'hA1); push_word(8'hA2); push_word(8'hA3);
    publish();
    ok = 1'b0;
    for (int unsigned i = 0; i < 10 && !ok; i++) begin
      @(negedge rclk);
      if (rclken) ok = 1'b1;
    end
    check("p2_first_issue", ok, 1'b1);
    @(negedge rclk); check("p2_issue2", rclken, 1'b1);
    @(negedge rclk); check("p2_issue3", rclken, 1'b1);
    @(negedge rclk); check("p2_issue_end", rclken, 1'b0);
    check("p2_valid_a2", s.m_valid, 1'b1);
    @(negedge rclk); check("p2_valid_a3", s.m_valid, 1'b1);
    @(negedge rclk); check("p2_valid_end", s.m_valid, 1'b0);
    check("p2_rempty", rempty, 1'b1);
    check("p2_rptr", rptr, 5'b00010);
    check("p2_dataq", exp_d.size(), 0);

    // Three words under backpressure
    @(posedge rclk); #1;
    ready_dir = 1'b0;
    push_word(8'hB1); push_word(8'hB2); push_word(8'hB3);
    publish();
    n = 0;
    repeat (12) begin
      @(negedge rclk);
      if (rclken) n++;
    end
    check("p3_issue_count", n, 2);
    check("p3_valid", s.m_valid, 1'b1);
    check("p3_hold", s.m_data, 8'hB1);
    @(posedge rclk); #1 ready_dir = 1'b1;
    drain(40, "p3_drain");

    // 40 words with random ready, crossing the address wrap
    @(posedge rclk); #1;
    rnd = 1'b1;
    saw_wrap = 1'b0; msb_toggles = 0; prev_msb = rptr[4]; track_msb = 1'b1;
    for (int c = 0; c < 5; c++) begin
      ok = 1'b0;
      for (int unsigned i = 0; i < 200 && !ok; i++) begin
        @(posedge rclk); #1;
        if (exp_d.size() <= 4) ok = 1'b1;
      end
      check("p4_space", ok, 1'b1);
      for (int k = 0; k < 8; k++) push_word(8'(8'h40 + c * 8 + k));
      publish();
    end
    drain(600, "p4_drain");
    track_msb = 1'b0;
    @(posedge rclk); #1 rnd = 1'b0;
    check("p4_wrap", saw_wrap, 1'b1);
    check("p4_msb_toggles", msb_toggles, 2);
    check("p4_rempty", rempty, 1'b1);
    check("p4_rptr", rptr, 5'b01001);

    // Reset with a word in flight and one buffered
    @(posedge rclk); #1;
    ready_dir = 1'b0;
    push_word(8'hD1); push_word(8'hD2); push_word(8'hD3); push_word(8'hD4);
    publish();
    ok = 1'b0;
    for (int unsigned i = 0; i < 10 && !ok; i++) begin
      @(negedge rclk);
      if (s.m_valid) ok = 1'b1;
    end
    check("p5_buffered", ok, 1'b1);
    rrst = 1'b1;
    exp_d.delete(); exp_a.delete();
    wbin = '0; rq2_wptr = '0;
    @(negedge rclk);
    rrst = 1'b0;
    @(negedge rclk);
    check("p5_after_reset", {s.m_valid, rempty, rptr, raddr}, {1'b0, 1'b1, 5'b00000, 4'd0});
    for (int i = 0; i < 5; i++) begin
      @(negedge rclk);
      check("p5_quiet", {s.m_valid, rclken}, 2'b00);
    end

    // Write pointer advances in the cycle of the last issue
    @(posedge rclk); #1;
    ready_dir = 1'b1;
    push_word(8'hC1); push_word(8'hC2);
    publish();
    ok = 1'b0;
    for (int unsigned i = 0; i < 10 && !ok; i++) begin
      @(negedge rclk);
      if (rclken && raddr == 4'd1) ok = 1'b1;
    end
    check("p6_second_issue", ok, 1'b1);
    push_word(8'hC3);
    publish();
    @(negedge rclk);
    check("p6_no_bubble", {rclken, raddr, rempty}, {1'b1, 4'd2, 1'b0});
    drain(40, "p6_drain");
    check("p6_rptr", rptr, 5'b00010);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
